// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin sequencer for the unified memory port shared by
//               the IF and MEM stages, with an acknowledge timeout watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int unsigned   CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);
    localparam logic          c_wd_en   = (TIMEOUT != 0);
    localparam logic          c_sel_if  = 1'b0;
    localparam logic          c_sel_dm  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_gnt;
    logic            w_gnt_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_grant;
    logic            w_grant_dm;
    logic            w_resp;
    logic            w_resp_err;
    logic [31:0]     w_resp_rdata;
    logic            w_other_req;

    // The requester not currently granted; only consulted in RESP.
    assign w_other_req = (r_gnt == c_sel_dm) ? if_req : dm_req;

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_last_nxt   = r_last;
        w_cnt_nxt    = r_cnt;
        w_grant      = 1'b0;
        w_grant_dm   = 1'b0;
        w_resp       = 1'b0;
        w_resp_err   = 1'b0;
        w_resp_rdata = '0;

        case (r_state)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    w_grant    = 1'b1;
                    w_grant_dm = (if_req && dm_req) ? (r_last == c_sel_if) : dm_req;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (mem_ack) begin
                    w_resp       = 1'b1;
                    w_resp_rdata = mem_we ? 32'd0 : mem_rdata;
                end else if (c_wd_en && (r_cnt == c_timeout)) begin
                    w_resp     = 1'b1;
                    w_resp_err = 1'b1;
                end
                if (w_resp) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_last_nxt  = r_gnt;
                w_state_nxt = S_IDLE;
                if (w_other_req) begin
                    w_grant    = 1'b1;
                    w_grant_dm = ~r_gnt;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_grant) begin
            w_state_nxt = S_ISSUE;
            w_gnt_nxt   = w_grant_dm;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= c_sel_if;
            r_last  <= c_sel_if;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The mem_* field registers double as the latched request of the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            mem_en <= w_grant;
            if (w_grant) begin
                mem_we    <= w_grant_dm & dm_we;
                mem_be    <= w_grant_dm ? dm_be    : 4'hF;
                mem_addr  <= w_grant_dm ? dm_addr  : if_addr;
                mem_wdata <= w_grant_dm ? dm_wdata : 32'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            err      <= 1'b0;
            if_rdata <= 32'd0;
            dm_rdata <= 32'd0;
        end else begin
            if_ready <= w_resp & (r_gnt == c_sel_if);
            dm_ready <= w_resp & (r_gnt == c_sel_dm);
            err      <= w_resp_err;
            if (w_resp && (r_gnt == c_sel_if)) begin
                if_rdata <= w_resp_rdata;
            end
            if (w_resp && (r_gnt == c_sel_dm)) begin
                dm_rdata <= w_resp_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a scripted memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_be    (dm_be),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          at;
    } mem_exp_t;

    typedef struct {
        logic        is_dm;
        logic [31:0] rdata;
        logic        err;
        int          at;
    } rsp_exp_t;

    typedef struct {
        int          delay;
        logic [31:0] data;
    } mem_script_t;

    mem_exp_t    q_mem[$];
    rsp_exp_t    q_rsp[$];
    mem_script_t q_script[$];

    int          checks   = 0;
    int          failures = 0;
    int          ack_cycle   = -1;
    int          stray_cycle = -1;
    logic [31:0] ack_data    = 32'd0;
    logic        prev_en     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_mem(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, input int at);
        mem_exp_t e;
        e.addr = addr; e.we = we; e.be = be; e.wdata = wdata; e.at = at;
        q_mem.push_back(e);
    endtask

    task automatic push_rsp(input logic is_dm, input logic [31:0] rdata, input logic e_err,
                            input int at);
        rsp_exp_t e;
        e.is_dm = is_dm; e.rdata = rdata; e.err = e_err; e.at = at;
        q_rsp.push_back(e);
    endtask

    // delay = cycles from mem_en to mem_ack; 0 means the memory never answers
    task automatic push_script(input int delay, input logic [31:0] data);
        mem_script_t s;
        s.delay = delay; s.data = data;
        q_script.push_back(s);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic if_access(input logic [31:0] addr);
        if_addr = addr;
        if_req  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            next_cyc();
            if (!rst_n || if_ready) break;
            if (i == 63) begin
                checks++;
                failures++;
                $display("FAIL if_ready_wait: no if_ready within 64 cycles, expected a pulse");
            end
        end
        if_req = 1'b0;
    endtask

    task automatic dm_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wdata);
        dm_we    = we;
        dm_be    = be;
        dm_addr  = addr;
        dm_wdata = wdata;
        dm_req   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            next_cyc();
            if (!rst_n || dm_ready) break;
            if (i == 63) begin
                checks++;
                failures++;
                $display("FAIL dm_ready_wait: no dm_ready within 64 cycles, expected a pulse");
            end
        end
        dm_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_rdata"},  if_rdata,  32'd0);
        chk({tag, "_if_ready"},  {31'd0, if_ready}, 32'd0);
        chk({tag, "_dm_rdata"},  dm_rdata,  32'd0);
        chk({tag, "_dm_ready"},  {31'd0, dm_ready}, 32'd0);
        chk({tag, "_mem_en"},    {31'd0, mem_en},   32'd0);
        chk({tag, "_mem_we"},    {31'd0, mem_we},   32'd0);
        chk({tag, "_mem_be"},    {28'd0, mem_be},   32'd0);
        chk({tag, "_mem_addr"},  mem_addr,  32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_err"},       {31'd0, err},      32'd0);
    endtask

    // Scripted memory: drives mem_ack/mem_rdata just after each rising edge
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            next_cyc();
            if (cyc == ack_cycle) begin
                mem_ack   = 1'b1;
                mem_rdata = ack_data;
            end else if (cyc == stray_cycle) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h0BAD_F00D;
            end
        end
    end

    // Monitor: compares every memory strobe and every ready against the queues
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 1'b0;
            end else begin
                if (mem_en) begin
                    chk("mem_en_single_cycle", {31'd0, prev_en}, 32'd0);
                    if (q_mem.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mem_en_unexpected: got strobe addr %h, expected none", mem_addr);
                    end else begin
                        mem_exp_t e;
                        e = q_mem.pop_front();
                        chk("mem_addr",  mem_addr,            e.addr);
                        chk("mem_we",    {31'd0, mem_we},     {31'd0, e.we});
                        chk("mem_be",    {28'd0, mem_be},     {28'd0, e.be});
                        chk("mem_wdata", mem_wdata,           e.wdata);
                        chk("mem_en_cycle", 32'(cyc),         32'(e.at));
                    end
                    if (q_script.size() != 0) begin
                        mem_script_t s;
                        s = q_script.pop_front();
                        if (s.delay > 0) begin
                            ack_cycle = cyc + s.delay;
                            ack_data  = s.data;
                        end
                    end
                end
                prev_en = mem_en;
                if (if_ready || dm_ready || err) begin
                    if (q_rsp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL ready_unexpected: got if_ready=%b dm_ready=%b err=%b, expected none",
                                 if_ready, dm_ready, err);
                    end else begin
                        rsp_exp_t r;
                        r = q_rsp.pop_front();
                        chk("rsp_who",   {30'd0, dm_ready, if_ready}, r.is_dm ? 32'd2 : 32'd1);
                        chk("rsp_rdata", r.is_dm ? dm_rdata : if_rdata, r.rdata);
                        chk("rsp_err",   {31'd0, err}, {31'd0, r.err});
                        chk("rsp_cycle", 32'(cyc), 32'(r.at));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        int lat[3];
        lat = '{1, 3, 7};
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_be = '0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        next_cyc();
        rst_n = 1'b1;
        next_cyc();

        // Single fetch, one-cycle memory latency
        c = cyc;
        push_script(1, 32'h2001_0005);
        push_mem(32'h100, 1'b0, 4'hF, 32'd0, c + 1);
        push_rsp(1'b0, 32'h2001_0005, 1'b0, c + 3);
        if_access(32'h100);
        next_cyc();

        // Tie with last=IF: DM first, IF strobed right after the DM ready
        c = cyc;
        push_script(1, 32'h1111_1111);
        push_script(1, 32'h2222_2222);
        push_mem(32'h400, 1'b0, 4'hF, 32'd0, c + 1);
        push_mem(32'h200, 1'b0, 4'hF, 32'd0, c + 4);
        push_rsp(1'b1, 32'h1111_1111, 1'b0, c + 3);
        push_rsp(1'b0, 32'h2222_2222, 1'b0, c + 6);
        fork
            if_access(32'h200);
            dm_access(1'b0, 4'hF, 32'h400, 32'd0);
        join
        next_cyc();

        // Halfword store, latency 2; load data from memory must not leak
        c = cyc;
        push_script(2, 32'h5555_5555);
        push_mem(32'h8, 1'b1, 4'h3, 32'hDEAD_BEEF, c + 1);
        push_rsp(1'b1, 32'd0, 1'b0, c + 4);
        dm_access(1'b1, 4'b0011, 32'h8, 32'hDEAD_BEEF);
        next_cyc();

        // Tie with last=DM: IF wins this time
        c = cyc;
        push_script(1, 32'h3333_3333);
        push_script(1, 32'h4444_4444);
        push_mem(32'h300, 1'b0, 4'hF, 32'd0, c + 1);
        push_mem(32'h404, 1'b0, 4'hF, 32'd0, c + 4);
        push_rsp(1'b0, 32'h3333_3333, 1'b0, c + 3);
        push_rsp(1'b1, 32'h4444_4444, 1'b0, c + 6);
        fork
            if_access(32'h300);
            dm_access(1'b0, 4'hF, 32'h404, 32'd0);
        join
        next_cyc();

        // Variable latency fetches
        for (int i = 0; i < 3; i++) begin
            c = cyc;
            push_script(lat[i], 32'hA000_0000 + 32'(lat[i]));
            push_mem(32'h1000 + 32'(4 * i), 1'b0, 4'hF, 32'd0, c + 1);
            push_rsp(1'b0, 32'hA000_0000 + 32'(lat[i]), 1'b0, c + 2 + lat[i]);
            if_access(32'h1000 + 32'(4 * i));
            next_cyc();
        end

        // Timeout: no ack ever, ready+err TIMEOUT+2 cycles after mem_en
        c = cyc;
        push_script(0, 32'd0);
        push_mem(32'h500, 1'b0, 4'hF, 32'd0, c + 1);
        push_rsp(1'b1, 32'd0, 1'b1, c + 1 + int'(TO) + 2);
        dm_access(1'b0, 4'hF, 32'h500, 32'd0);
        stray_cycle = cyc + 2;
        repeat (3) next_cyc();
        c = cyc;
        push_script(1, 32'h6666_6666);
        push_mem(32'h504, 1'b0, 4'hF, 32'd0, c + 1);
        push_rsp(1'b1, 32'h6666_6666, 1'b0, c + 3);
        dm_access(1'b0, 4'hF, 32'h504, 32'd0);
        next_cyc();

        // Reset during WAIT aborts the fetch without a ready
        c = cyc;
        push_script(5, 32'h7777_0000);
        push_mem(32'h600, 1'b0, 4'hF, 32'd0, c + 1);
        fork
            if_access(32'h600);
            begin
                repeat (3) next_cyc();
                #1 rst_n = 1'b0;
                #1 chk_all_zero("abort");
                repeat (2) next_cyc();
                ack_cycle = -1;
                rst_n = 1'b1;
            end
        join
        next_cyc();

        // First tie after reset goes to DM
        c = cyc;
        push_script(1, 32'h8888_0001);
        push_script(1, 32'h8888_0002);
        push_mem(32'h704, 1'b0, 4'hF, 32'd0, c + 1);
        push_mem(32'h700, 1'b0, 4'hF, 32'd0, c + 4);
        push_rsp(1'b1, 32'h8888_0001, 1'b0, c + 3);
        push_rsp(1'b0, 32'h8888_0002, 1'b0, c + 6);
        fork
            if_access(32'h700);
            dm_access(1'b0, 4'hF, 32'h704, 32'd0);
        join
        next_cyc();

        // Plain fetch after recovery
        c = cyc;
        push_script(2, 32'h9999_0009);
        push_mem(32'h800, 1'b0, 4'hF, 32'd0, c + 1);
        push_rsp(1'b0, 32'h9999_0009, 1'b0, c + 4);
        if_access(32'h800);

        repeat (4) next_cyc();
        chk("rsp_queue_drained", 32'(q_rsp.size()), 32'd0);
        chk("mem_queue_drained", 32'(q_mem.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
